// File: rtl/hist_pkg.sv
// Shared types for the histogram counting stage.
package hist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        COUNT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } hist_state_e;

endpackage

// File: rtl/hist_count_pipeline_unpack.sv
// hist_lane_unpack: fetches packed source words and emits one pixel per cycle,
// prefetching the next word during the final lane so the stream has no gaps.
module hist_lane_unpack
    import hist_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int ADDR_W       = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          go_i,
    input  logic [ADDR_W-1:0]             base_i,
    input  logic [ADDR_W-1:0]             num_i,
    input  logic [PIX_W*PIX_PER_WORD-1:0] src_rdata_i,
    output logic [ADDR_W-1:0]             src_raddr_o,
    output logic [PIX_W-1:0]              pix_o,
    output logic                          pix_valid_o,
    output logic                          pix_last_o
);

    localparam int SRC_W  = PIX_W * PIX_PER_WORD;
    localparam int LANE_W = (PIX_PER_WORD > 2) ? $clog2(PIX_PER_WORD) : 1;

    // Lane 0 is taken straight from the RAM output, so only the upper lanes are held.
    logic [SRC_W-PIX_W-1:0] word_q;
    logic [LANE_W-1:0]      lane_q, cur_lane;
    logic [ADDR_W-1:0]      raddr_q, left_q;
    logic                   rd_q, dv_q, issue;

    always_comb begin
        cur_lane    = dv_q ? '0 : lane_q;
        pix_valid_o = dv_q || (lane_q != '0);
        pix_o       = '0;
        if (dv_q)
            pix_o = src_rdata_i[PIX_W-1:0];
        else if (lane_q != '0)
            pix_o = word_q[(int'(lane_q) - 1) * PIX_W +: PIX_W];
        issue      = pix_valid_o && (cur_lane == LANE_W'(PIX_PER_WORD - 2)) && (left_q != '0);
        pix_last_o = pix_valid_o && (cur_lane == LANE_W'(PIX_PER_WORD - 1)) && (left_q == '0) && !rd_q;
    end

    assign src_raddr_o = raddr_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            lane_q  <= '0;
            raddr_q <= '0;
            left_q  <= '0;
            rd_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            rd_q <= go_i || issue;
            dv_q <= rd_q;
            if (go_i) begin
                raddr_q <= base_i;
                left_q  <= num_i - ADDR_W'(1);
            end else if (issue) begin
                raddr_q <= raddr_q + ADDR_W'(1);
                left_q  <= left_q - ADDR_W'(1);
            end
            if (dv_q) begin
                word_q <= src_rdata_i[SRC_W-1:PIX_W];
                lane_q <= LANE_W'(1);
            end else if (lane_q != '0) begin
                lane_q <= (lane_q == LANE_W'(PIX_PER_WORD - 1)) ? '0 : lane_q + LANE_W'(1);
            end
        end
    end

endmodule

// File: rtl/hist_count_pipeline.sv
// hist_count_pipeline: zeroes the bin table, then read-modify-writes one counter per pixel.
// Define HIST_SAT_EN for saturating counters and the sticky sat_flag_o port; otherwise counters wrap.
//   state | meaning
//   IDLE  | waiting for start_i
//   CLEAR | writing zero to one bin per cycle
//   COUNT | pixels entering S0
//   DRAIN | last pixel issued, S1/S2 emptying
//   DONE  | one-cycle completion pulse
module hist_count_pipeline
    import hist_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 20,
    parameter int BIN_BASE     = 0
) (
    input  logic                          clock_i,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             src_base_i,
    input  logic [ADDR_W-1:0]             num_words_i,
    output logic [ADDR_W-1:0]             src_raddr_o,
    input  logic [PIX_W*PIX_PER_WORD-1:0] src_rdata_i,
    output logic [ADDR_W-1:0]             bin_raddr_o,
    input  logic [CNT_W-1:0]              bin_rdata_i,
    output logic [ADDR_W-1:0]             bin_waddr_o,
    output logic [CNT_W-1:0]              bin_wdata_o,
    output logic                          bin_we_o,
    output logic                          busy_o,
    output logic                          done_o
`ifdef HIST_SAT_EN
    ,
    output logic                          sat_flag_o
`endif
);

    typedef struct packed {
        logic             valid;
        logic [PIX_W-1:0] bin;
        logic [CNT_W-1:0] count;
    } pipe_stage_t;

    hist_state_e       state_q, state_d;
    logic [PIX_W-1:0]  clr_q, clr_d;
    logic [ADDR_W-1:0] base_q, num_q;
    logic              s1_valid_q;
    logic [PIX_W-1:0]  s1_bin_q;
    pipe_stage_t       s2_q, s2_d, lw_q, wr;
    logic [PIX_W-1:0]  pix;
    logic              pix_valid, pix_last, pix_ok, go, start_ok;
    logic [CNT_W-1:0]  fwd_cnt, inc_cnt;

    assign start_ok = (state_q == IDLE) && start_i;
    assign pix_ok   = pix_valid && (state_q == COUNT);
    assign go       = (state_q == CLEAR) && (&clr_q) && (num_q != '0);

    hist_lane_unpack #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD),
        .ADDR_W       (ADDR_W)
    ) u_unpack (
        .clk_i       (clock_i),
        .rst_n       (rst_n),
        .go_i        (go),
        .base_i      (base_q),
        .num_i       (num_q),
        .src_rdata_i (src_rdata_i),
        .src_raddr_o (src_raddr_o),
        .pix_o       (pix),
        .pix_valid_o (pix_valid),
        .pix_last_o  (pix_last)
    );

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE:  begin
                clr_d = '0;
                if (start_i) state_d = CLEAR;
            end
            CLEAR: begin
                clr_d = clr_q + PIX_W'(1);
                if (&clr_q) state_d = (num_q == '0) ? DONE : COUNT;
            end
            COUNT: if (pix_ok && pix_last) state_d = DRAIN;
            DRAIN: if (!s1_valid_q) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The scratchpad cannot yet show writes from S2 now or from the previous cycle.
    always_comb begin
        if (s2_q.valid && (s2_q.bin == s1_bin_q))
            fwd_cnt = s2_q.count;
        else if (lw_q.valid && (lw_q.bin == s1_bin_q))
            fwd_cnt = lw_q.count;
        else
            fwd_cnt = bin_rdata_i;
`ifdef HIST_SAT_EN
        inc_cnt = (fwd_cnt == '1) ? fwd_cnt : fwd_cnt + CNT_W'(1);
`else
        inc_cnt = fwd_cnt + CNT_W'(1);
`endif
        s2_d.valid = s1_valid_q;
        s2_d.bin   = s1_bin_q;
        s2_d.count = inc_cnt;
    end

    always_comb begin
        wr.valid = (state_q == CLEAR) || s2_q.valid;
        wr.bin   = (state_q == CLEAR) ? clr_q : s2_q.bin;
        wr.count = (state_q == CLEAR) ? '0 : s2_q.count;
    end

    assign bin_we_o    = wr.valid;
    assign bin_waddr_o = wr.valid ? ADDR_W'(BIN_BASE) + ADDR_W'(wr.bin) : '0;
    assign bin_wdata_o = wr.valid ? wr.count : '0;
    assign bin_raddr_o = pix_ok ? ADDR_W'(BIN_BASE) + ADDR_W'(pix) : '0;
    assign busy_o      = (state_q == CLEAR) || (state_q == COUNT) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);

    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_q      <= '0;
            base_q     <= '0;
            num_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s2_q       <= '0;
            lw_q       <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            if (start_ok) begin
                base_q <= src_base_i;
                num_q  <= num_words_i;
            end
            s1_valid_q <= pix_ok;
            s1_bin_q   <= pix;
            s2_q       <= s2_d;
            lw_q       <= wr;
        end
    end

`ifdef HIST_SAT_EN
    logic sat_q;

    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else if (start_ok)
            sat_q <= 1'b0;
        else if (s1_valid_q && (fwd_cnt == '1))
            sat_q <= 1'b1;
    end

    assign sat_flag_o = sat_q;
`endif

endmodule

// File: tb/tb_hist_count_pipeline.sv
// Randomized scoreboard bench for hist_count_pipeline with behavioural RAMs and a histogram model.
module tb_hist_count_pipeline;

    localparam int PIX_W    = 8;
    localparam int PPW      = 16;
    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 6;
    localparam int BIN_BASE = 16'h0100;
    localparam int SRC_W    = PIX_W * PPW;
    localparam int NBINS    = 1 << PIX_W;
    localparam int MAXC     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [CNT_W-1:0]  d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n, start_i;
    logic [ADDR_W-1:0] src_base_i, num_words_i, src_raddr, bin_raddr, bin_waddr;
    logic [SRC_W-1:0]  src_rdata;
    logic [CNT_W-1:0]  bin_rdata, bin_wdata;
    logic              bin_we, busy, done;
`ifdef HIST_SAT_EN
    logic              sat_flag;
    bit                sat_exp;
`endif

    always #5 clk = ~clk;

    hist_count_pipeline #(
        .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BIN_BASE(BIN_BASE)
    ) dut (
        .clock_i     (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .src_base_i  (src_base_i),
        .num_words_i (num_words_i),
        .src_raddr_o (src_raddr),
        .src_rdata_i (src_rdata),
        .bin_raddr_o (bin_raddr),
        .bin_rdata_i (bin_rdata),
        .bin_waddr_o (bin_waddr),
        .bin_wdata_o (bin_wdata),
        .bin_we_o    (bin_we),
        .busy_o      (busy),
        .done_o      (done)
`ifdef HIST_SAT_EN
        ,
        .sat_flag_o  (sat_flag)
`endif
    );

    logic [SRC_W-1:0]  src_mem [0:65535];
    logic [CNT_W-1:0]  bin_mem [0:65535];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_a  = '0;
    logic [CNT_W-1:0]  pre_d  = '0;

    always @(posedge clk) begin
        src_rdata <= src_mem[src_raddr];
        bin_rdata <= bin_mem[bin_raddr];
        if (bin_we)
            bin_mem[bin_waddr] <= bin_wdata;
        else if (pre_we)
            bin_mem[pre_a] <= pre_d;
    end

    int  cyc = 0;
    int  n_cmp = 0, n_bad = 0;
    int  t0 = 0, exp_done = 0, done_cnt = 0;
    logic prev_we = 1'b0;
    wr_t exp_q [$];
    int  mcnt [NBINS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every scratchpad write is popped against the expected write stream.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (bin_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bin_waddr, bin_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bin_waddr, e.a);
                    chk("wr_data", bin_wdata, e.d);
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                chk("done_after_last_we", prev_we, 1);
                chk("done_cycle", cyc - t0, exp_done);
                chk("busy_at_done", busy, 0);
            end
            prev_we <= bin_we;
        end else begin
            prev_we <= 1'b0;
        end
    end

    function automatic logic [PIX_W-1:0] gen_pix(input int mode, input int k,
                                                 input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        case (mode)
            0:       return PIX_W'($urandom_range(0, NBINS - 1));
            1:       return a + PIX_W'($urandom_range(0, 3));
            2:       return (k % 2 == 0) ? a : b;
            3:       return a;
            default: return PIX_W'(k);
        endcase
    endfunction

    task automatic fill(input logic [ADDR_W-1:0] base, input int n, input int mode,
                        input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [SRC_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int k = 0; k < PPW; k++) w[k*PIX_W +: PIX_W] = gen_pix(mode, k, a, b);
            src_mem[base + ADDR_W'(i)] = w;
        end
    endtask

    // Reference histogram: clear writes first, then one write per pixel in stream order.
    task automatic prep(input logic [ADDR_W-1:0] base, input int n);
        logic [SRC_W-1:0] w;
        logic [PIX_W-1:0] p;
        wr_t e;
        exp_q.delete();
`ifdef HIST_SAT_EN
        sat_exp = 1'b0;
`endif
        for (int b = 0; b < NBINS; b++) begin
            mcnt[b] = 0;
            e.a = ADDR_W'(BIN_BASE + b);
            e.d = '0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            w = src_mem[base + ADDR_W'(i)];
            for (int k = 0; k < PPW; k++) begin
                p = w[k*PIX_W +: PIX_W];
                if (mcnt[p] == MAXC) begin
`ifdef HIST_SAT_EN
                    sat_exp = 1'b1;
`else
                    mcnt[p] = 0;
`endif
                end else begin
                    mcnt[p]++;
                end
                e.a = ADDR_W'(BIN_BASE + int'(p));
                e.d = CNT_W'(mcnt[p]);
                exp_q.push_back(e);
            end
        end
        exp_done = (n == 0) ? NBINS + 1 : NBINS + 4 + PPW * n;
    endtask

    task automatic kick(input logic [ADDR_W-1:0] base, input int n);
        @(posedge clk); #1;
        start_i     = 1'b1;
        src_base_i  = base;
        num_words_i = ADDR_W'(n);
        t0          = cyc;
        @(posedge clk); #1;
        start_i     = 1'b0;
        src_base_i  = ADDR_W'($urandom);
        num_words_i = ADDR_W'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    // mode 1: extra start while busy; mode 2: extra start coincident with done.
    task automatic run(input logic [ADDR_W-1:0] base, input int n, input int mode);
        int dc0;
        bit seen;
        logic [ADDR_W-1:0] raddr0;
        prep(base, n);
        raddr0 = src_raddr;
        dc0 = done_cnt;
        kick(base, n);
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(posedge clk); #1;
            start_i = ((mode == 2) && (cyc == t0 + exp_done)) || ((mode == 1) && (cyc == t0 + 20));
            if (done_cnt != dc0) seen = 1'b1;
        end
        start_i = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 4000 cycles");
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            exp_q.delete();
            return;
        end
        chk("pending_writes", exp_q.size(), 0);
        chk("busy_after_done", busy, 0);
        if (n == 0) chk("src_raddr_unchanged", src_raddr, raddr0);
        if (mode == 2) begin
            repeat (5) @(posedge clk);
            #1 chk("start_at_done_ignored", busy, 0);
        end
        for (int b = 0; b < NBINS; b++)
            chk($sformatf("bin_%0h", b), bin_mem[ADDR_W'(BIN_BASE + b)], mcnt[b]);
`ifdef HIST_SAT_EN
        chk("sat_flag", sat_flag, sat_exp);
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        src_base_i  = '0;
        num_words_i = '0;
        for (int b = 0; b < NBINS; b++) begin
            @(posedge clk); #1;
            pre_we = 1'b1;
            pre_a  = ADDR_W'(BIN_BASE + b);
            pre_d  = CNT_W'($urandom);
        end
        @(posedge clk); #1;
        pre_we = 1'b0;
        chk("rst_bin_we", bin_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_src_raddr", src_raddr, 0);
        chk("rst_bin_raddr", bin_raddr, 0);
        chk("rst_bin_waddr", bin_waddr, 0);
        chk("rst_bin_wdata", bin_wdata, 0);
`ifdef HIST_SAT_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        fill(16'h0010, 1, 4, 8'h00, 8'h00);
        run(16'h0010, 1, 0);
        fill(16'h0200, 4, 3, 8'h37, 8'h00);
        run(16'h0200, 4, 0);
        fill(16'h0300, 2, 2, 8'h5A, 8'hA5);
        run(16'h0300, 2, 0);
        run(16'h1234, 0, 0);
        for (int r = 0; r < 6; r++) begin
            logic [ADDR_W-1:0] b;
            int n;
            b = (r == 3) ? 16'hFFFD : ADDR_W'($urandom);
            n = $urandom_range(1, 6);
            fill(b, n, r % 3, PIX_W'($urandom), PIX_W'($urandom));
            run(b, n, (r == 1) ? 1 : (r == 4) ? 2 : 0);
        end

        fill(16'h0400, 4, 1, 8'hC0, 8'h00);
        prep(16'h0400, 4);
        kick(16'h0400, 4);
        repeat (269) @(posedge clk);
        #1 chk("we_before_abort", bin_we, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_bin_we", bin_we, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(16'h0400, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
